// File: rtl/rac_handshake_hub_pkg.sv
// Shared types and the rotating-priority pick used by the handshake hub.
package rac_pkg;

  typedef enum logic [1:0] {IDLE, ACK, XFER, RELEASE} state_e;

  localparam int RR_MAX   = 16;
  localparam int RR_IDX_W = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping at nch; nch <= RR_MAX.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input logic [RR_IDX_W:0]   nch);
    rr_pick_t            res;
    logic [RR_IDX_W:0]   c;
    res = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      c = {1'b0, ptr} + (RR_IDX_W+1)'(i);
      if (c >= nch) c = c - nch;
      if (!res.found && ((RR_IDX_W+1)'(i) < nch) && req[c[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = c[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rac_handshake_hub_if.sv
// Requester/sink bundle of the handshake hub; the hub uses the slave side.
interface rac_handshake_hub_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]        req_i;
  logic [NCH-1:0]        commit_i;
  logic [NCH*DATA_W-1:0] data_i;
  logic [NCH-1:0]        ack_o;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  tick_o;
  logic                  err_o;
  logic [CH_W-1:0]       err_ch;
  logic [CNT_W-1:0]      txn_cnt;

  modport master (
    output req_i, commit_i, data_i, out_ready,
    input  ack_o, out_valid, out_data, out_ch, tick_o, err_o, err_ch, txn_cnt
  );

  modport slave (
    input  req_i, commit_i, data_i, out_ready,
    output ack_o, out_valid, out_data, out_ch, tick_o, err_o, err_ch, txn_cnt
  );

endinterface

// File: rtl/rac_handshake_hub_rr_arbiter.sv
// Combinational rotating-priority pick; the pointer register is owned by the hub.
module rac_rr_arbiter
  import rac_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic            o_found,
  output logic [CH_W-1:0] o_idx
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick = rr_pick(RR_MAX'(i_req), RR_IDX_W'(i_ptr), (RR_IDX_W+1)'(NCH));
  end

  assign o_found = w_pick.found;
  assign o_idx   = CH_W'(w_pick.idx);

endmodule

// File: rtl/rac_handshake_hub.sv
// N-channel req/ack/commit responder: round-robin grant, capture on commit,
// valid/ready forward, tick-based timeout and saturating transaction count.
module rac_handshake_hub
  import rac_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DATA_W   = 8,
  parameter int DIV_LOG2 = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  rac_handshake_hub_if.slave bus
);

  localparam int CH_W = $clog2(NCH);

  state_e             r_state, w_state_next;
  logic [CH_W-1:0]    r_grant, w_grant_next;
  logic [CH_W-1:0]    r_rr_ptr, w_rr_ptr_next;
  logic [7:0]         r_timer, w_timer_next;
  logic [DATA_W-1:0]  r_out_data, w_out_data_next;
  logic [CH_W-1:0]    r_out_ch, w_out_ch_next;
  logic               r_err, w_err_next;
  logic [CH_W-1:0]    r_err_ch, w_err_ch_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               w_tick;
  logic               w_found;
  logic [CH_W-1:0]    w_pick;
  logic [DATA_W-1:0]  w_lane [NCH];

  generate
    if (DIV_LOG2 == 0) begin : g_tick_every
      assign w_tick = ~rst;
    end else begin : g_tick_div
      logic [DIV_LOG2-1:0] r_div;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_div <= '0;
        else     r_div <= r_div + 1'b1;
      end
      assign w_tick = &r_div;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      assign w_lane[gi] = bus.data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rac_rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .i_req   (bus.req_i),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_timer    <= '0;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_err      <= 1'b0;
      r_err_ch   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_timer    <= w_timer_next;
      r_out_data <= w_out_data_next;
      r_out_ch   <= w_out_ch_next;
      r_err      <= w_err_next;
      r_err_ch   <= w_err_ch_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_rr_ptr_next   = r_rr_ptr;
    w_timer_next    = r_timer;
    w_out_data_next = r_out_data;
    w_out_ch_next   = r_out_ch;
    w_err_next      = 1'b0;
    w_err_ch_next   = r_err_ch;
    w_cnt_next      = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_tick && w_found) begin
          w_state_next = ACK;
          w_grant_next = w_pick;
          w_timer_next = '0;
        end
      end
      ACK: begin
        // Commit outranks both a dropped request and timer expiry.
        if (bus.commit_i[r_grant]) begin
          w_out_data_next = w_lane[r_grant];
          w_out_ch_next   = r_grant;
          w_state_next    = XFER;
        end else if (!bus.req_i[r_grant]) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          if (r_timer + 8'd1 == 8'(TIMEOUT)) begin
            w_err_next    = 1'b1;
            w_err_ch_next = r_grant;
            w_state_next  = RELEASE;
          end else begin
            w_timer_next = r_timer + 8'd1;
          end
        end
      end
      XFER: begin
        if (bus.out_ready) begin
          if (r_cnt != '1) w_cnt_next = r_cnt + 1'b1;
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.req_i[r_grant] && !bus.commit_i[r_grant]) begin
          w_rr_ptr_next = (r_grant == CH_W'(NCH - 1)) ? '0 : r_grant + 1'b1;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Decoded from the registered state so ack falls with rst asynchronously.
  assign bus.ack_o     = (r_state == ACK || r_state == XFER) ? (NCH'(1) << r_grant) : '0;
  assign bus.out_valid = (r_state == XFER);
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.tick_o    = w_tick;
  assign bus.err_o     = r_err;
  assign bus.err_ch    = r_err_ch;
  assign bus.txn_cnt   = r_cnt;

endmodule

// File: tb/tb_rac_handshake_hub.sv
// Directed plus randomized bench for rac_handshake_hub against a transaction-level model.
module tb_rac_handshake_hub;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;
  int   m_cnt   = 0;

  rac_handshake_hub_if #(.NCH(4), .DATA_W(8), .CNT_W(16)) if0 ();
  rac_handshake_hub_if #(.NCH(4), .DATA_W(8), .CNT_W(16)) if3 ();

  rac_handshake_hub #(.NCH(4), .DATA_W(8), .DIV_LOG2(0), .TIMEOUT(TO), .CNT_W(16)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  rac_handshake_hub #(.NCH(4), .DATA_W(8), .DIV_LOG2(3), .TIMEOUT(TO), .CNT_W(16)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] mask, input int ptr);
    int c;
    for (int i = 0; i < 4; i++) begin
      c = (ptr + i) % 4;
      if (mask[2'(c)]) return c;
    end
    return -1;
  endfunction

  // One requester transaction on dut0; model tracks the rr pointer and the count.
  task automatic txn(input string tag, input logic [3:0] mask, input logic [31:0] dword,
                     input int cdly, input int rdly, input bit abandon);
    int         g;
    logic [3:0] gbit;
    logic [7:0] dg;
    g    = pick(mask, m_ptr);
    gbit = 4'(1 << g);
    dg   = dword[g*8 +: 8];
    if0.data_i    = dword;
    if0.req_i     = mask;
    if0.commit_i  = '0;
    if0.out_ready = (rdly == 0);
    cyc();
    chk({tag, ".ack"}, 32'(if0.ack_o), 32'(gbit));
    if (abandon) begin
      if0.req_i = '0;
      cyc();
      chk({tag, ".ack_drop"}, 32'(if0.ack_o), 32'd0);
      chk({tag, ".no_err"}, 32'(if0.err_o), 32'd0);
      chk({tag, ".cnt"}, 32'(if0.txn_cnt), 32'(m_cnt));
      cyc();
      chk({tag, ".idle"}, 32'(if0.ack_o), 32'd0);
    end else begin
      for (int k = 0; k < cdly; k++) begin
        if0.commit_i = 4'($urandom) & ~gbit;
        cyc();
        chk({tag, ".ack_hold"}, 32'(if0.ack_o), 32'(gbit));
        chk({tag, ".wait_valid"}, 32'(if0.out_valid), 32'd0);
        chk({tag, ".wait_err"}, 32'(if0.err_o), 32'd0);
      end
      if0.commit_i = gbit;
      cyc();
      chk({tag, ".valid"}, 32'(if0.out_valid), 32'd1);
      chk({tag, ".data"}, 32'(if0.out_data), 32'(dg));
      chk({tag, ".ch"}, 32'(if0.out_ch), 32'(g));
      chk({tag, ".xfer_ack"}, 32'(if0.ack_o), 32'(gbit));
      chk({tag, ".commit_err"}, 32'(if0.err_o), 32'd0);
      for (int k = 0; k < rdly; k++) begin
        cyc();
        chk({tag, ".bp_valid"}, 32'(if0.out_valid), 32'd1);
        chk({tag, ".bp_data"}, 32'(if0.out_data), 32'(dg));
        chk({tag, ".bp_cnt"}, 32'(if0.txn_cnt), 32'(m_cnt));
      end
      if0.out_ready = 1'b1;
      cyc();
      m_cnt++;
      chk({tag, ".cnt"}, 32'(if0.txn_cnt), 32'(m_cnt));
      chk({tag, ".done_valid"}, 32'(if0.out_valid), 32'd0);
      chk({tag, ".rel_ack"}, 32'(if0.ack_o), 32'd0);
      cyc();
      chk({tag, ".rel_hold"}, 32'(if0.ack_o), 32'd0);
      if0.req_i     = '0;
      if0.commit_i  = '0;
      if0.out_ready = 1'b0;
      cyc();
      m_ptr = (g + 1) % 4;
    end
  endtask

  initial begin
    int         obs_g;
    int         prev_g;
    int         n;
    bit         pend;
    bit         granted;
    logic [7:0] d4;
    if0.req_i = '0; if0.commit_i = '0; if0.data_i = '0; if0.out_ready = 1'b0;
    if3.req_i = '0; if3.commit_i = '0; if3.data_i = '0; if3.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ack", 32'(if0.ack_o), 32'd0);
    chk("rst.valid", 32'(if0.out_valid), 32'd0);
    chk("rst.tick", 32'(if0.tick_o), 32'd0);
    chk("rst.err", 32'(if0.err_o), 32'd0);
    chk("rst.cnt", 32'(if0.txn_cnt), 32'd0);
    chk("rst.data", 32'(if0.out_data), 32'd0);
    rst = 1'b0;
    #1;
    chk("tick.always", 32'(if0.tick_o), 32'd1);

    // 1: single transfer ch1 with 0xA5
    txn("t1", 4'b0010, 32'h0000_A500, 1, 0, 1'b0);

    // 3: timeout on ch2
    if0.req_i = 4'b0100;
    cyc();
    chk("t3.ack", 32'(if0.ack_o), 32'h4);
    for (int k = 1; k < TO; k++) begin
      cyc();
      chk("t3.no_err", 32'(if0.err_o), 32'd0);
      chk("t3.ack_hold", 32'(if0.ack_o), 32'h4);
    end
    cyc();
    chk("t3.err", 32'(if0.err_o), 32'd1);
    chk("t3.err_ch", 32'(if0.err_ch), 32'd2);
    chk("t3.ack_drop", 32'(if0.ack_o), 32'd0);
    chk("t3.cnt", 32'(if0.txn_cnt), 32'(m_cnt));
    cyc();
    chk("t3.pulse", 32'(if0.err_o), 32'd0);
    chk("t3.err_ch_hold", 32'(if0.err_ch), 32'd2);
    if0.req_i = '0;
    cyc();
    m_ptr = 3;

    // 5a: abandon on ch3, then 6: commit collides with timer expiry
    txn("t5a", 4'b1000, $urandom, 0, 0, 1'b1);
    txn("t6", 4'b1000, $urandom, TO - 1, 0, 1'b0);

    // 5b: reset during XFER discards the word and clears everything at once
    if0.data_i = 32'h0000_003C;
    if0.req_i  = 4'b0001;
    cyc();
    chk("t5b.ack", 32'(if0.ack_o), 32'h1);
    if0.commit_i = 4'b0001;
    cyc();
    chk("t5b.valid", 32'(if0.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5b.ack0", 32'(if0.ack_o), 32'd0);
    chk("t5b.valid0", 32'(if0.out_valid), 32'd0);
    chk("t5b.data0", 32'(if0.out_data), 32'd0);
    chk("t5b.cnt0", 32'(if0.txn_cnt), 32'd0);
    if0.req_i = '0; if0.commit_i = '0;
    cyc();
    rst = 1'b0;
    m_cnt = 0;
    m_ptr = 0;

    // 2: fairness with every channel requesting
    if0.data_i    = $urandom;
    if0.req_i     = 4'hF;
    if0.out_ready = 1'b1;
    prev_g = -1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fair.ack", 32'(if0.ack_o), 32'(1 << (k % 4)));
      obs_g = -1;
      for (int c = 0; c < 4; c++) if (if0.ack_o[c]) obs_g = c;
      chk("fair.not_repeat", 32'(obs_g == prev_g), 32'd0);
      prev_g = obs_g;
      if0.commit_i = 4'(1 << (k % 4));
      cyc();
      chk("fair.ch", 32'(if0.out_ch), 32'(k % 4));
      cyc();
      m_cnt++;
      chk("fair.cnt", 32'(if0.txn_cnt), 32'(m_cnt));
      if0.req_i    = 4'hF & ~4'(1 << (k % 4));
      if0.commit_i = '0;
      cyc();
      if0.req_i = 4'hF;
    end
    if0.req_i     = '0;
    if0.out_ready = 1'b0;
    cyc();
    m_ptr = 1;

    // Randomized transactions
    for (int k = 0; k < 25; k++) begin
      txn("rnd", 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, TO - 1),
          $urandom_range(0, 4), ($urandom_range(0, 4) == 0));
    end

    // 4: divided tick and backpressure on dut3
    n = 0;
    while (if3.tick_o !== 1'b1 && n < 32) begin cyc(); n++; end
    chk("t4.tick_seen", 32'(if3.tick_o), 32'd1);
    cyc();
    n = 1;
    while (if3.tick_o !== 1'b1 && n < 32) begin cyc(); n++; end
    chk("t4.period", 32'(n), 32'd8);
    cyc();
    d4 = 8'($urandom);
    if3.data_i = {16'h0, d4, 8'h0};
    if3.req_i  = 4'b0010;
    pend    = if3.tick_o;
    granted = 1'b0;
    for (int k = 0; k < 16 && !granted; k++) begin
      cyc();
      if (pend) begin
        chk("t4.ack", 32'(if3.ack_o), 32'h2);
        granted = 1'b1;
      end else begin
        chk("t4.wait", 32'(if3.ack_o), 32'd0);
      end
      pend = if3.tick_o;
    end
    chk("t4.granted", 32'(granted), 32'd1);
    if3.commit_i = 4'b0010;
    cyc();
    chk("t4.valid", 32'(if3.out_valid), 32'd1);
    chk("t4.data", 32'(if3.out_data), 32'(d4));
    if3.data_i = ~if3.data_i;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("t4.bp_valid", 32'(if3.out_valid), 32'd1);
      chk("t4.bp_data", 32'(if3.out_data), 32'(d4));
      chk("t4.bp_cnt", 32'(if3.txn_cnt), 32'd0);
    end
    if3.out_ready = 1'b1;
    cyc();
    chk("t4.cnt", 32'(if3.txn_cnt), 32'd1);
    chk("t4.done", 32'(if3.out_valid), 32'd0);
    if3.req_i = '0; if3.commit_i = '0; if3.out_ready = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
